sarlock_seq_unlock: RTL and testbench



---
 rtl/sarlock_seq_unlock.sv | 139 +++++++++++++
 tb/tb_sarlock_seq_unlock.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sarlock_seq_unlock.sv
// SARLock sequential unlock: serial key load, atomic commit, registered flip.
// Ports: clk, rst_n, key_in_* serial handshake, key_clear, key_loaded,
//        cmp_valid/cmp_in/protected_in -> prot_out/prot_out_valid, attempt_cnt.
// Option: define SARLOCK_ATTEMPT_CNT_EN to build the wrong-commit counter.
module sarlock_seq_unlock #(
    parameter int               KEY_W     = 16,
    parameter int               OUT_W     = 7,
    parameter logic [KEY_W-1:0] SECRET    = 16'h3563,
    parameter logic [OUT_W-1:0] FLIP_MASK = 7'h40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_in_valid,
    input  logic             key_in_bit,
    output logic             key_in_ready,
    input  logic             key_clear,
    output logic             key_loaded,
    input  logic             cmp_valid,
    input  logic [KEY_W-1:0] cmp_in,
    input  logic [OUT_W-1:0] protected_in,
    output logic [OUT_W-1:0] prot_out,
    output logic             prot_out_valid,
    output logic [7:0]       attempt_cnt
);

    localparam int            CW   = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(KEY_W - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic [KEY_W-1:0]   active_q, active_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [OUT_W-1:0]   prot_q;
    logic               pvalid_q;
    logic               commit;
    logic               ready;
    logic               flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        commit   = 1'b0;
        ready    = 1'b0;
        case (state_q)
            EMPTY, LOADING: begin
                ready = 1'b1;
                if (key_in_valid && !key_clear) begin
                    shadow_d[cnt_q] = key_in_bit;
                    if (cnt_q == LAST) begin
                        commit = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = LOADING;
                    end
                end
            end
            ARMED: begin
                ready = 1'b0;
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Commit copies the shadow including the bit accepted this cycle.
        if (commit) begin
            active_d = shadow_d;
            cnt_d    = '0;
            state_d  = ARMED;
        end
        // Clear beats any simultaneous key bit, including the final one.
        if (key_clear) begin
            state_d  = EMPTY;
            shadow_d = '0;
            active_d = '0;
            cnt_d    = '0;
        end
    end

    assign key_in_ready = ready;
    assign key_loaded   = (state_q == ARMED);

    // Compare against the key as registered before this edge.
    assign flip = (cmp_in == active_q) && (active_q != SECRET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prot_q   <= '0;
            pvalid_q <= 1'b0;
        end else begin
            pvalid_q <= cmp_valid;
            if (cmp_valid) begin
                prot_q <= protected_in ^ (flip ? FLIP_MASK : '0);
            end
        end
    end

    assign prot_out       = prot_q;
    assign prot_out_valid = pvalid_q;

`ifdef SARLOCK_ATTEMPT_CNT_EN
    logic [7:0] attempt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            attempt_q <= 8'd0;
        end else if (commit && !key_clear && (shadow_d != SECRET)
                     && (attempt_q != 8'hFF)) begin
            attempt_q <= attempt_q + 8'd1;
        end
    end

    assign attempt_cnt = attempt_q;
`else
    assign attempt_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sarlock_seq_unlock.sv
// Directed bench for sarlock_seq_unlock with default parameters.
// Checks reset, flip behaviour, serial load, clear priority and commit timing.
module tb_sarlock_seq_unlock;

    logic        clk;
    logic        rst_n;
    logic        key_in_valid;
    logic        key_in_bit;
    logic        key_in_ready;
    logic        key_clear;
    logic        key_loaded;
    logic        cmp_valid;
    logic [15:0] cmp_in;
    logic [6:0]  protected_in;
    logic [6:0]  prot_out;
    logic        prot_out_valid;
    logic [7:0]  attempt_cnt;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_att;

    sarlock_seq_unlock dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in_valid  (key_in_valid),
        .key_in_bit    (key_in_bit),
        .key_in_ready  (key_in_ready),
        .key_clear     (key_clear),
        .key_loaded    (key_loaded),
        .cmp_valid     (cmp_valid),
        .cmp_in        (cmp_in),
        .protected_in  (protected_in),
        .prot_out      (prot_out),
        .prot_out_valid(prot_out_valid),
        .attempt_cnt   (attempt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift(input logic [15:0] k, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            key_in_valid = 1'b1;
            key_in_bit   = k[i];
            tick();
        end
        key_in_valid = 1'b0;
        key_in_bit   = 1'b0;
    endtask

    task automatic cmp(input logic [15:0] c, input logic [6:0] p);
        cmp_valid    = 1'b1;
        cmp_in       = c;
        protected_in = p;
        tick();
        cmp_valid    = 1'b0;
    endtask

    initial begin
`ifdef SARLOCK_ATTEMPT_CNT_EN
        exp_att = 8'd1;
`else
        exp_att = 8'd0;
`endif
        rst_n        = 1'b0;
        key_in_valid = 1'b0;
        key_in_bit   = 1'b0;
        key_clear    = 1'b0;
        cmp_valid    = 1'b0;
        cmp_in       = '0;
        protected_in = '0;
        tick();
        chk("rst_prot_out", 32'(prot_out), 32'h00);
        chk("rst_valid", 32'(prot_out_valid), 32'h0);
        chk("rst_loaded", 32'(key_loaded), 32'h0);
        chk("rst_ready", 32'(key_in_ready), 32'h1);
        chk("rst_attempt", 32'(attempt_cnt), 32'h0);
        rst_n = 1'b1;
        tick();

        cmp(16'h0000, 7'h15);
        chk("empty_flip0", 32'(prot_out), 32'h55);
        chk("empty_valid", 32'(prot_out_valid), 32'h1);
        cmp(16'h0001, 7'h15);
        chk("empty_noflip", 32'(prot_out), 32'h15);
        tick();
        chk("idle_valid", 32'(prot_out_valid), 32'h0);
        chk("idle_hold", 32'(prot_out), 32'h15);

        shift(16'h3563, 0, 14);
        chk("ld15_loaded", 32'(key_loaded), 32'h0);
        chk("ld15_ready", 32'(key_in_ready), 32'h1);
        shift(16'h3563, 15, 15);
        chk("ld16_loaded", 32'(key_loaded), 32'h1);
        chk("ld16_ready", 32'(key_in_ready), 32'h0);
        cmp(16'h3563, 7'h15);
        chk("sec_match", 32'(prot_out), 32'h15);
        cmp(16'h0000, 7'h15);
        chk("sec_zero", 32'(prot_out), 32'h15);
        chk("sec_attempt", 32'(attempt_cnt), 32'h0);
        shift(16'hFFFF, 0, 0);
        chk("armed_extra", 32'(key_loaded), 32'h1);

        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        chk("clr_loaded", 32'(key_loaded), 32'h0);
        chk("clr_ready", 32'(key_in_ready), 32'h1);
        cmp(16'h0000, 7'h00);
        chk("clr_flip0", 32'(prot_out), 32'h40);

        shift(16'hABCD, 0, 15);
        chk("bad_loaded", 32'(key_loaded), 32'h1);
        cmp(16'hABCD, 7'h00);
        chk("bad_match", 32'(prot_out), 32'h40);
        cmp(16'h1234, 7'h00);
        chk("bad_other", 32'(prot_out), 32'h00);
        cmp(16'hABCD, 7'h2A);
        chk("bad_match2", 32'(prot_out), 32'h6A);
        chk("bad_attempt", 32'(attempt_cnt), 32'(exp_att));

        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        shift(16'h3563, 0, 14);
        key_clear    = 1'b1;
        key_in_valid = 1'b1;
        key_in_bit   = 1'b0;
        tick();
        key_clear    = 1'b0;
        key_in_valid = 1'b0;
        chk("clrwin_loaded", 32'(key_loaded), 32'h0);
        chk("clrwin_ready", 32'(key_in_ready), 32'h1);
        chk("clrwin_attempt", 32'(attempt_cnt), 32'(exp_att));
        cmp(16'h0000, 7'h15);
        chk("clrwin_key0", 32'(prot_out), 32'h55);

        shift(16'hABCD, 0, 7);
        rst_n = 1'b0;
        #1;
        chk("midrst_prot", 32'(prot_out), 32'h00);
        chk("midrst_attempt", 32'(attempt_cnt), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        shift(16'h3563, 0, 14);
        chk("rl15_loaded", 32'(key_loaded), 32'h0);
        shift(16'h3563, 15, 15);
        chk("rl16_loaded", 32'(key_loaded), 32'h1);
        cmp(16'h3563, 7'h15);
        chk("rl_match", 32'(prot_out), 32'h15);
        cmp(16'h0000, 7'h15);
        chk("rl_zero", 32'(prot_out), 32'h15);
        chk("rl_attempt", 32'(attempt_cnt), 32'h0);

        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        shift(16'h3563, 0, 14);
        key_in_valid = 1'b1;
        key_in_bit   = 1'b0;
        cmp_valid    = 1'b1;
        cmp_in       = 16'h0000;
        protected_in = 7'h15;
        tick();
        key_in_valid = 1'b0;
        chk("same_old_key", 32'(prot_out), 32'h55);
        chk("same_loaded", 32'(key_loaded), 32'h1);
        cmp(16'h0000, 7'h15);
        chk("same_new_key", 32'(prot_out), 32'h15);
        cmp(16'h3563, 7'h15);
        chk("same_sec", 32'(prot_out), 32'h15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
